// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } lsu_state_e;

    // Illegal sizes come back as an all-zero mask; they never reach the bus.
    function automatic logic [31:0] size_to_mask(input logic [1:0] sz);
        case (lsu_size_e'(sz))
            BYTE:    return 32'h0000_00FF;
            HALF:    return 32'h0000_FFFF;
            WORD:    return 32'hFFFF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic access_bad(input logic [1:0] sz, input logic [1:0] off);
        return (sz == 2'd3)
            || ((sz == HALF) && off[0])
            || ((sz == WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/size_mask_gen.sv
// Access-size to byte-lane mask decoder, shared by the load mask and the RMW merge.
// Latency: combinational.
// Backpressure: none.
module size_mask_gen
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    output logic [31:0] mask
);

    assign mask = size_to_mask(size);

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer over a 32-bit req/ack word bus, read-modify-write for sub-word stores.
// Latency: start->done 2 cycles (load, word store), 3 (sub-word store), 1 (error), plus ack wait.
// Backpressure: bus requests held until mem_ack; start ignored while busy, nothing is queued.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        write,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] data_out,
    output logic [31:0] mask_out,
    output logic        done,
    output logic        err,
    output logic        busy
);

    lsu_state_e  state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_d, mem_wdata_d, data_out_d, mask_out_d;
    logic        err_d;
    logic [31:0] size_mask;
    logic [4:0]  sh;

    assign sh = {off_q, 3'b000};

    size_mask_gen u_size_mask_gen (
        .size (size_q),
        .mask (size_mask)
    );

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        data_out_d  = data_out;
        mask_out_d  = mask_out;
        err_d       = err;
        case (state_q)
            IDLE: begin
                if (start) begin
                    write_d    = write;
                    size_d     = size;
                    off_d      = addr[1:0];
                    wdata_d    = wdata;
                    mem_addr_d = {addr[31:2], 2'b00};
                    if (access_bad(size, addr[1:0])) begin
                        state_d    = DONE;
                        err_d      = 1'b1;
                        data_out_d = '0;
                        mask_out_d = '0;
                    end else if (!write) begin
                        state_d = READ;
                    end else if (size == WORD) begin
                        state_d     = WRITE;
                        mem_wdata_d = wdata;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (mem_ack) begin
                    if (write_q) begin
                        // Sub-word store: splice the new lanes into the word just read.
                        mem_wdata_d = (mem_rdata & ~(size_mask << sh))
                                    | ((wdata_q & size_mask) << sh);
                        state_d     = WRITE;
                    end else begin
                        data_out_d = mem_rdata >> sh;
                        mask_out_d = size_mask;
                        err_d      = 1'b0;
                        state_d    = DONE;
                    end
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    data_out_d = '0;
                    mask_out_d = '0;
                    err_d      = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus strobes, done and busy are registered images of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            size_q    <= 2'd0;
            off_q     <= 2'd0;
            wdata_q   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            data_out  <= '0;
            mask_out  <= '0;
            err       <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            size_q    <= size_d;
            off_q     <= off_d;
            wdata_q   <= wdata_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            data_out  <= data_out_d;
            mask_out  <= mask_out_d;
            err       <= err_d;
            mem_rd    <= (state_d == READ);
            mem_wr    <= (state_d == WRITE);
            done      <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Timeline-driven bench for load_store_unit: a word-addressed memory model plus
// per-cycle expected outputs derived from the access rules, checked on every negedge.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] data_out;
    logic [31:0] mask_out;
    logic        done;
    logic        err;
    logic        busy;

    load_store_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .write     (write),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .data_out  (data_out),
        .mask_out  (mask_out),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    // Expected state for the current cycle
    bit        chk_en = 1'b0;
    bit        exp_rst = 1'b0;
    bit        exp_rd, exp_wr, exp_done, exp_busy;
    bit [31:0] exp_addr, exp_wdata;
    bit        m_err;
    bit [31:0] m_data, m_mask;

    // Observations used by directed checks
    int        n_done = 0, n_rd = 0, n_wr = 0;
    int        last_done_cyc = 0, start_cyc = 0;
    bit [31:0] seen_addr, seen_wdata;

    bit [31:0] mem [bit [29:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv)
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
        else
            n_pass++;
    endtask

    function automatic bit [31:0] mem_read(input bit [29:0] w);
        if (!mem.exists(w)) mem[w] = $urandom;
        return mem[w];
    endfunction

    function automatic bit [31:0] lane_mask(input bit [1:0] sz);
        return (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input bit rd, input bit wr, input bit dn, input bit bz);
        exp_rd = rd; exp_wr = wr; exp_done = dn; exp_busy = bz;
    endtask

    task automatic junk_inputs(input bit with_start);
        start = with_start;
        write = 1'($urandom);
        size  = 2'($urandom);
        addr  = $urandom;
        wdata = $urandom;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("ctrl{rd,wr,done,busy,err}", {27'b0, mem_rd, mem_wr, done, busy, err},
                    {27'b0, exp_rd, exp_wr, exp_done, exp_busy, m_err});
                chk("data_out", data_out, m_data);
                chk("mask_out", mask_out, m_mask);
                if (exp_rd || exp_wr) chk("mem_addr", mem_addr, exp_addr);
                if (exp_wr) chk("mem_wdata", mem_wdata, exp_wdata);
                if (exp_rst) begin
                    chk("rst_mem_addr", mem_addr, 32'h0);
                    chk("rst_mem_wdata", mem_wdata, 32'h0);
                end
            end
            if (done === 1'b1) begin n_done++; last_done_cyc = cyc; end
            if (mem_rd === 1'b1) begin n_rd++; seen_addr = mem_addr; end
            if (mem_wr === 1'b1) begin n_wr++; seen_wdata = mem_wdata; end
        end
    end

    // One access, starting in an idle cycle; dr/dw are the request lengths
    // in cycles (ack arrives in the last one). Returns in the idle cycle after done.
    task automatic run_txn(input bit wr, input bit [1:0] sz, input bit [31:0] a,
                           input bit [31:0] wd, input int dr, input int dw, input bit noise);
        bit        bad;
        int        nrd, nwr, off;
        bit [31:0] word, neww;
        off  = int'(a[1:0]);
        bad  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        nrd  = bad ? 0 : ((!wr || sz != 2'd2) ? dr : 0);
        nwr  = (bad || !wr) ? 0 : dw;
        word = mem_read(a[31:2]);
        neww = word;
        if (wr && !bad) begin
            if (sz == 2'd2) neww = wd;
            else for (int i = 0; i < ((sz == 2'd0) ? 1 : 2); i++)
                neww[8*(off+i) +: 8] = wd[8*i +: 8];
        end

        start = 1'b1; write = wr; size = sz; addr = a; wdata = wd;
        mem_ack = noise ? 1'($urandom) : 1'b0;
        mem_rdata = $urandom;
        start_cyc = cyc;
        step();
        exp_rst  = 1'b0;
        exp_addr = {a[31:2], 2'b00};
        for (int k = 1; k <= nrd; k++) begin
            set_exp(1, 0, 0, 1);
            junk_inputs(noise && (k == 1 || $urandom_range(0, 1) == 1));
            mem_ack   = (k == nrd);
            mem_rdata = (k == nrd) ? word : $urandom;
            step();
        end
        for (int k = 1; k <= nwr; k++) begin
            set_exp(0, 1, 0, 1);
            exp_wdata = neww;
            junk_inputs(noise && (k == 1 || $urandom_range(0, 1) == 1));
            mem_ack   = (k == nwr);
            mem_rdata = $urandom;
            step();
        end
        if (nwr > 0) mem[a[31:2]] = neww;
        set_exp(0, 0, 1, 1);
        m_err  = bad;
        m_data = (!bad && !wr) ? (word >> (8 * off)) : 32'h0;
        m_mask = (!bad && !wr) ? lane_mask(sz) : 32'h0;
        junk_inputs(noise && $urandom_range(0, 1) == 1);
        mem_ack   = noise ? 1'($urandom) : 1'b0;
        mem_rdata = $urandom;
        step();
        set_exp(0, 0, 0, 0);
        junk_inputs(1'b0);
        mem_ack = 1'b0;
    endtask

    initial begin
        int d0, r0, w0;
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        junk_inputs(1'b0);
        step();
        step();
        set_exp(0, 0, 0, 0);
        m_err = 0; m_data = 0; m_mask = 0; exp_rst = 1'b1;
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Word load, ack one cycle after mem_rd rises
        mem[30'h40] = 32'h12312312;
        d0 = n_done;
        run_txn(1'b0, 2'd2, 32'h100, 32'h0, 2, 1, 1'b0);
        chk("word_load_data", data_out, 32'h12312312);
        chk("word_load_mask", mask_out, 32'hFFFFFFFF);
        chk("word_load_err", {31'b0, err}, 32'h0);
        chk("word_load_latency", last_done_cyc - start_cyc, 32'd3);
        chk("word_load_ndone", n_done - d0, 32'd1);

        // Byte load from the top lane
        mem[30'h40] = 32'hAB345678;
        run_txn(1'b0, 2'd0, 32'h103, 32'h0, 1, 1, 1'b0);
        chk("byte_load_addr", seen_addr, 32'h100);
        chk("byte_load_data", data_out, 32'h000000AB);
        chk("byte_load_mask", mask_out, 32'h000000FF);
        chk("byte_load_latency", last_done_cyc - start_cyc, 32'd2);

        // Reset in the middle of a word store
        d0 = n_done;
        start = 1'b1; write = 1'b1; size = 2'd2; addr = 32'h300; wdata = 32'hCAFEF00D;
        step();
        exp_rst = 1'b0;
        set_exp(0, 1, 0, 1); exp_addr = 32'h300; exp_wdata = 32'hCAFEF00D;
        junk_inputs(1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_exp(0, 0, 0, 0); exp_rst = 1'b1;
        m_err = 0; m_data = 0; m_mask = 0;
        step();
        step();
        chk("rst_no_done", n_done - d0, 32'd0);
        mem[30'hC1] = 32'h5A5A1234;
        run_txn(1'b0, 2'd2, 32'h304, 32'h0, 1, 1, 1'b0);
        chk("post_rst_load", data_out, 32'h5A5A1234);

        // Half store read-modify-write
        mem[30'h80] = 32'h11223344;
        d0 = n_done; r0 = n_rd; w0 = n_wr;
        run_txn(1'b1, 2'd1, 32'h202, 32'h0000BEEF, 1, 1, 1'b0);
        chk("half_store_wdata", seen_wdata, 32'hBEEF3344);
        chk("half_store_nrd", n_rd - r0, 32'd1);
        chk("half_store_nwr", n_wr - w0, 32'd1);
        chk("half_store_ndone", n_done - d0, 32'd1);
        chk("half_store_latency", last_done_cyc - start_cyc, 32'd3);
        chk("half_store_data_clr", data_out, 32'h0);

        // Misaligned word load
        r0 = n_rd; w0 = n_wr;
        run_txn(1'b0, 2'd2, 32'h101, 32'h0, 1, 1, 1'b0);
        chk("misalign_latency", last_done_cyc - start_cyc, 32'd1);
        chk("misalign_err", {31'b0, err}, 32'h1);
        chk("misalign_no_bus", (n_rd - r0) + (n_wr - w0), 32'd0);
        chk("misalign_mask", mask_out, 32'h0);

        // Ack held off five cycles with stray starts during the access
        d0 = n_done; r0 = n_rd;
        run_txn(1'b0, 2'd2, 32'h400, 32'h0, 6, 1, 1'b1);
        chk("held_ack_ndone", n_done - d0, 32'd1);
        chk("held_ack_nrd", n_rd - r0, 32'd6);

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            int  s;
            bit [1:0] sz;
            s  = $urandom_range(0, 9);
            sz = (s == 9) ? 2'd3 : 2'(s % 3);
            run_txn(1'($urandom), sz, $urandom_range(0, 4095), $urandom,
                    $urandom_range(1, 4), $urandom_range(1, 4), 1'($urandom));
            if ($urandom_range(0, 3) == 0) step();
        end

        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access sequencer between the CPU control unit and the memory bus. Runs byte/half/word loads and stores over a 32-bit word bus with a request/ack handshake, and does read-modify-write for sub-word stores. For loads it presents the right-aligned read word and an access-size mask. These feed directly into `mask_filter` (`in`, `mask`), which produces the final loaded value.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request strobe. Sampled only in IDLE.
- `write` in 1: 1 = store, 0 = load. Captured with `start`.
- `size` in 2: access size: BYTE=0, HALF=1, WORD=2; 3 is illegal. Captured with `start`.
- `addr` in 32: byte address. Captured with `start`.
- `wdata` in 32: store data, right-aligned. Captured with `start`.
- `mem_addr` out 32: word-aligned bus address, `{addr[31:2], 2'b00}`.
- `mem_wdata` out 32: bus write data.
- `mem_rd` out 1: bus read request. Held until ack.
- `mem_wr` out 1: bus write request. Held until ack.
- `mem_rdata` in 32: bus read data. Valid when `mem_ack` is high.
- `mem_ack` in 1: bus acknowledge for the current request.
- `data_out` out 32: load result, `mem_rdata >> (8*addr[1:0])`. Upper bits are not cleared here.
- `mask_out` out 32: BYTE → `0x000000FF`, HALF → `0x0000FFFF`, WORD → `0xFFFFFFFF`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; 1 = misaligned or illegal access.
- `busy` out 1: high in every state except IDLE.

## Operation
States: IDLE, READ, WRITE, DONE.

IDLE → on `start`: capture the inputs, then:
- illegal size, HALF with `addr[0]=1`, or WORD with `addr[1:0]≠0` → DONE with `err=1`. No bus access.
- load → READ.
- WORD store → WRITE, with `mem_wdata = wdata`.
- BYTE/HALF store → READ (read-modify-write).

READ:
- `mem_rd = 1` until a cycle with `mem_ack = 1`.
- On ack, the load path latches `data_out` and `mask_out` and goes to DONE.
- On ack, the RMW path latches `mem_wdata = (mem_rdata & ~(m << sh)) | ((wdata & m) << sh)` and goes to WRITE. Here `m` is the size mask and `sh = 8*addr[1:0]`.

WRITE:
- `mem_wr = 1` until `mem_ack`, then → DONE.

DONE:
- `done = 1` for exactly one cycle, then → IDLE.

Output holding and error rules:
- `data_out` and `mask_out` hold their value until the next load completes.
- Stores and errors drive both to 0.
- `err` holds until the next `done`.

`start` outside IDLE is ignored; no queuing.

`mem_ack` while neither `mem_rd` nor `mem_wr` is asserted is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE
  - `mem_rd`, `mem_wr`, `done`, `err`, `busy` = 0
  - `mem_addr`, `mem_wdata`, `data_out`, `mask_out` = 0
- `start` in cycle 0 → `mem_rd` or `mem_wr` high in cycle 1.
- Ack sampled in cycle N → request drops in cycle N+1.
- In the same cycle N+1, either `done` is high, or (RMW) `mem_wr` rises.
- Minimum latency from `start` to `done` with a zero-wait ack:
  - load or word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- `rst` at any point, including mid-request, forces every output to its reset value on the next edge.
  - The aborted access produces no `done`.
  - The bus must tolerate an abandoned request.

## Structure
- Shared package `lsu_pkg`:
  - `lsu_size_e` (BYTE/HALF/WORD)
  - `lsu_state_e`
  - function or constant for the size-to-mask mapping
- One sub-module, `size_mask_gen`: combinational, `size` → 32-bit mask. It is used both for `mask_out` and for the RMW merge.
- The load result is not filtered internally; `mask_filter` downstream applies `mask_out`.

## Test plan
- Word load: addr `0x100`, ack 1 cycle after `mem_rd` with rdata `0x12312312` → `data_out=0x12312312`, `mask_out=0xFFFFFFFF`, `done` 3 cycles after `start`, `err=0`.
- Byte load: addr `0x103`, rdata `0xAB345678` → `mem_addr=0x100`, `data_out=0x000000AB`, `mask_out=0x000000FF`.
- Half store: addr `0x202`, wdata `0x0000BEEF`, read returns `0x11223344` → one read then one write with `mem_wdata=0xBEEF3344`, one `done`.
- Misaligned word load: addr `0x101` → `done=1`, `err=1` one cycle after `start`; `mem_rd`/`mem_wr` never asserted; `data_out=mask_out=0`.
- Ack held off 5 cycles, with a second `start` mid-access → `mem_rd` stays high throughout, the second `start` is ignored, and exactly one `done` occurs.
- `rst` asserted during WRITE → next cycle all outputs 0 and `busy=0`; no `done`; a fresh load afterwards completes normally.
